// File: rtl/direct_sound_pkg.sv
// Shared constants and types for the GBA direct-sound FIFO controller.
package direct_sound_pkg;

    localparam int unsigned SAMPLE_W   = 8;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned FIFO_DEPTH = 8;
    // Wide enough to hold 0..FIFO_DEPTH words.
    localparam int unsigned COUNT_W    = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } dma_state_t;

endpackage

// File: rtl/direct_sound_fifo_ctrl_if.sv
// CPU/DMA/timer side bus of the direct-sound controller.
// The master drives writes, timer pulses and acks; the slave is the controller.
interface direct_sound_fifo_ctrl_if;
    import direct_sound_pkg::*;

    logic                sound_en;
    logic                timer_sel_a;
    logic                timer_sel_b;
    logic                timer0_ovf;
    logic                timer1_ovf;
    logic                fifo_a_reset;
    logic                fifo_b_reset;
    logic                fifo_a_wr;
    logic                fifo_b_wr;
    logic [WORD_W-1:0]   fifo_a_wdata;
    logic [WORD_W-1:0]   fifo_b_wdata;
    logic                dma_ack_a;
    logic                dma_ack_b;
    logic                dma_req_a;
    logic                dma_req_b;
    logic [SAMPLE_W-1:0] sample_a;
    logic [SAMPLE_W-1:0] sample_b;
    logic [COUNT_W-1:0]  count_a;
    logic [COUNT_W-1:0]  count_b;
    logic                underrun_a;
    logic                underrun_b;
    logic                overflow_a;
    logic                overflow_b;

    modport master (
        output sound_en, timer_sel_a, timer_sel_b, timer0_ovf, timer1_ovf,
        output fifo_a_reset, fifo_b_reset, fifo_a_wr, fifo_b_wr,
        output fifo_a_wdata, fifo_b_wdata, dma_ack_a, dma_ack_b,
        input  dma_req_a, dma_req_b, sample_a, sample_b, count_a, count_b,
        input  underrun_a, underrun_b, overflow_a, overflow_b
    );

    modport slave (
        input  sound_en, timer_sel_a, timer_sel_b, timer0_ovf, timer1_ovf,
        input  fifo_a_reset, fifo_b_reset, fifo_a_wr, fifo_b_wr,
        input  fifo_a_wdata, fifo_b_wdata, dma_ack_a, dma_ack_b,
        output dma_req_a, dma_req_b, sample_a, sample_b, count_a, count_b,
        output underrun_a, underrun_b, overflow_a, overflow_b
    );

endinterface

// File: rtl/sound_fifo_chan.sv
// One direct-sound channel: word FIFO, byte-wise sample selector and DMA refill FSM.
module sound_fifo_chan
    import direct_sound_pkg::*;
#(
    parameter int unsigned Depth        = FIFO_DEPTH,
    parameter int unsigned DmaThreshold = 4,
    parameter int unsigned BurstWords   = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                sound_en_i,
    input  logic                tick_i,
    input  logic                fifo_rst_i,
    input  logic                wr_i,
    input  logic [WORD_W-1:0]   wdata_i,
    input  logic                ack_i,
    output logic                dma_req_o,
    output logic [SAMPLE_W-1:0] sample_o,
    output logic [COUNT_W-1:0]  count_o,
    output logic                underrun_o,
    output logic                overflow_o
);

    localparam int unsigned PtrW = $clog2(Depth);

    logic [WORD_W-1:0]   mem_q [Depth];
    logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [COUNT_W-1:0]  count_q, count_d;
    logic [1:0]          byte_idx_q, byte_idx_d;
    logic [SAMPLE_W-1:0] sample_q, sample_d;
    logic                underrun_q, underrun_d;
    logic                overflow_q, overflow_d;
    dma_state_t          state_q, state_d;
    logic                pending_q, pending_d;
    logic [COUNT_W-1:0]  burst_q, burst_d;

    logic not_empty, full, pop, wr_acc;

    assign not_empty = (count_q != '0);
    assign full      = (count_q == COUNT_W'(Depth));
    // A word leaves the FIFO when its last byte is played.
    assign pop       = tick_i & not_empty & (byte_idx_q == 2'd3);
    // A full FIFO still takes a write if a word is popped in the same cycle.
    assign wr_acc    = wr_i & (~full | pop);

    // FIFO pointers, occupancy, sample selection and error pulses.
    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        byte_idx_d = byte_idx_q;
        sample_d   = sample_q;
        underrun_d = 1'b0;
        overflow_d = 1'b0;
        if (fifo_rst_i) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            byte_idx_d = '0;
            sample_d   = '0;
        end else begin
            if (tick_i) begin
                if (not_empty) begin
                    sample_d   = mem_q[rd_ptr_q][{byte_idx_q, 3'b000} +: SAMPLE_W];
                    byte_idx_d = byte_idx_q + 2'd1;
                end else begin
                    underrun_d = 1'b1;
                end
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            overflow_d = wr_i & ~wr_acc;
            unique case ({wr_acc, pop})
                2'b10:   count_d = count_q + COUNT_W'(1);
                2'b01:   count_d = count_q - COUNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // DMA refill handshake: request, wait for the acknowledged burst, then re-arm.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        burst_d   = burst_q;
        if (fifo_rst_i) begin
            state_d   = IDLE;
            pending_d = 1'b0;
            burst_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (sound_en_i && !pending_q && count_q <= COUNT_W'(DmaThreshold)) begin
                        state_d = REQ;
                    end
                end
                REQ: begin
                    if (!sound_en_i) begin
                        state_d = IDLE;
                    end else if (ack_i) begin
                        state_d   = WAIT;
                        pending_d = 1'b1;
                        // A write in the ack cycle is already part of the burst.
                        burst_d   = wr_i ? COUNT_W'(BurstWords - 1) : COUNT_W'(BurstWords);
                    end
                end
                WAIT: begin
                    if (wr_i) begin
                        if (burst_q <= COUNT_W'(1)) begin
                            state_d   = IDLE;
                            pending_d = 1'b0;
                            burst_d   = '0;
                        end else begin
                            burst_d = burst_q - COUNT_W'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            byte_idx_q <= '0;
            sample_q   <= '0;
            underrun_q <= 1'b0;
            overflow_q <= 1'b0;
            state_q    <= IDLE;
            pending_q  <= 1'b0;
            burst_q    <= '0;
        end else begin
            if (wr_acc && !fifo_rst_i) begin
                mem_q[wr_ptr_q] <= wdata_i;
            end
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            byte_idx_q <= byte_idx_d;
            sample_q   <= sample_d;
            underrun_q <= underrun_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            pending_q  <= pending_d;
            burst_q    <= burst_d;
        end
    end

    assign dma_req_o  = (state_q == REQ);
    assign sample_o   = sample_q;
    assign count_o    = count_q;
    assign underrun_o = underrun_q;
    assign overflow_o = overflow_q;

endmodule

// File: rtl/direct_sound_fifo_ctrl.sv
// GBA direct-sound controller top: timer selection, master-enable gating and two channels.
module direct_sound_fifo_ctrl
    import direct_sound_pkg::*;
#(
    parameter int unsigned DEPTH         = FIFO_DEPTH,
    parameter int unsigned DMA_THRESHOLD = 4,
    parameter int unsigned BURST_WORDS   = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    direct_sound_fifo_ctrl_if.slave   bus_io
);

    logic                tick_a, tick_b;
    logic                dma_req_a, dma_req_b;
    logic [SAMPLE_W-1:0] sample_a, sample_b;
    logic [COUNT_W-1:0]  count_a, count_b;
    logic                underrun_a, underrun_b;
    logic                overflow_a, overflow_b;

    // Timer ticks only reach the channels while sound is enabled.
    assign tick_a = bus_io.sound_en &
                    (bus_io.timer_sel_a ? bus_io.timer1_ovf : bus_io.timer0_ovf);
    assign tick_b = bus_io.sound_en &
                    (bus_io.timer_sel_b ? bus_io.timer1_ovf : bus_io.timer0_ovf);

    sound_fifo_chan #(
        .Depth        (DEPTH),
        .DmaThreshold (DMA_THRESHOLD),
        .BurstWords   (BURST_WORDS)
    ) u_chan_a (
        .clk_i      (clock),
        .rst_i      (reset),
        .sound_en_i (bus_io.sound_en),
        .tick_i     (tick_a),
        .fifo_rst_i (bus_io.fifo_a_reset),
        .wr_i       (bus_io.fifo_a_wr),
        .wdata_i    (bus_io.fifo_a_wdata),
        .ack_i      (bus_io.dma_ack_a),
        .dma_req_o  (dma_req_a),
        .sample_o   (sample_a),
        .count_o    (count_a),
        .underrun_o (underrun_a),
        .overflow_o (overflow_a)
    );

    sound_fifo_chan #(
        .Depth        (DEPTH),
        .DmaThreshold (DMA_THRESHOLD),
        .BurstWords   (BURST_WORDS)
    ) u_chan_b (
        .clk_i      (clock),
        .rst_i      (reset),
        .sound_en_i (bus_io.sound_en),
        .tick_i     (tick_b),
        .fifo_rst_i (bus_io.fifo_b_reset),
        .wr_i       (bus_io.fifo_b_wr),
        .wdata_i    (bus_io.fifo_b_wdata),
        .ack_i      (bus_io.dma_ack_b),
        .dma_req_o  (dma_req_b),
        .sample_o   (sample_b),
        .count_o    (count_b),
        .underrun_o (underrun_b),
        .overflow_o (overflow_b)
    );

    assign bus_io.dma_req_a  = dma_req_a;
    assign bus_io.dma_req_b  = dma_req_b;
    assign bus_io.sample_a   = sample_a;
    assign bus_io.sample_b   = sample_b;
    assign bus_io.count_a    = count_a;
    assign bus_io.count_b    = count_b;
    assign bus_io.underrun_a = underrun_a;
    assign bus_io.underrun_b = underrun_b;
    assign bus_io.overflow_a = overflow_a;
    assign bus_io.overflow_b = overflow_b;

endmodule

// File: doc/direct_sound_fifo_ctrl.md
# direct_sound_fifo_ctrl

Controller that feeds the two direct-sound channels (A and B) of the GBA audio path. It buffers CPU/DMA word writes in two 8-word FIFOs and pops one signed 8-bit sample per selected timer overflow. It raises a DMA refill request when a FIFO runs low and presents the current sample of each channel to the downstream sound mixer.

## Interface
Parameters:
- DEPTH, 8: FIFO depth in 32-bit words, per channel.
- DMA_THRESHOLD, 4: a DMA request is raised when the word count is less than or equal to this value.
- BURST_WORDS, 4: number of words one acknowledged DMA request delivers.

Ports:
- clock  input  1  system clock; one clock, all state on its rising edge.
- reset  input  1  synchronous, active-high; all state and outputs go to 0.
- sound_en  input  1  master enable (SOUNDCNT_X bit 7); when 0, timer ticks and DMA requests are ignored or suppressed.
- timer_sel_a, timer_sel_b  input  1 each  timer select for each channel; 0 = timer0, 1 = timer1.
- timer0_ovf, timer1_ovf  input  1 each  single-cycle timer overflow pulses.
- fifo_a_reset, fifo_b_reset  input  1 each  single-cycle FIFO reset strobes.
- fifo_a_wr, fifo_b_wr  input  1 each  word write strobe.
- fifo_a_wdata, fifo_b_wdata  input  32 each  write data; the sample at [7:0] plays first.
- dma_ack_a, dma_ack_b  input  1 each  DMA accepted the request.
- dma_req_a, dma_req_b  output  1 each  level refill request, held until acknowledged.
- sample_a, sample_b  output  8 each  current signed sample, registered.
- count_a, count_b  output  4 each  words held, range 0..DEPTH.
- underrun_a, underrun_b  output  1 each  single-cycle pulse: tick arrived with the FIFO empty.
- overflow_a, overflow_b  output  1 each  single-cycle pulse: write dropped because the FIFO was full.

## Operation
The two channels are identical and independent. In the rules below, "x" stands for channel a or b.

- tick_x = sound_en & (timer_sel_x ? timer1_ovf : timer0_ovf).
- Per-channel state: count (0..8), rd_ptr and wr_ptr (3-bit, wrapping), byte_idx (2-bit), pending (1-bit).
- On tick_x with count > 0:
  - sample_x <= head_word[8*byte_idx +: 8] and byte_idx increments.
  - When byte_idx was 3, it wraps to 0, the head word is popped, rd_ptr increments and count decrements.
- On tick_x with count == 0: sample_x holds its value, underrun_x pulses, byte_idx is unchanged.
- Write when count < DEPTH:
  - The word is stored at wr_ptr, wr_ptr increments and count increments.
- Write when count == DEPTH:
  - If no word pop occurs in the same cycle, the write is dropped and overflow_x pulses.
  - If a word pop occurs in the same cycle, the write is accepted.
- Simultaneous accepted write and word pop: count is unchanged and both pointers advance.
- DMA handshake, per channel, as a 3-state FSM:
  - IDLE -> REQ when sound_en & !pending & count <= DMA_THRESHOLD. dma_req_x = 1 only in REQ.
  - REQ -> WAIT on dma_ack_x. pending is set, and the burst counter loads BURST_WORDS.
  - WAIT counts accepted or dropped writes. WAIT -> IDLE when the burst counter reaches 0, and pending clears.
  - REQ -> IDLE if sound_en falls.
- fifo_x_reset strobe:
  - count, pointers, byte_idx, sample_x and the FSM all return to 0/IDLE in the next cycle.
  - It has priority over a write, a tick and an ack in the same cycle; all of those are discarded.
- Output reset values: all outputs are 0.

## Timing
- sample_x changes on the clock edge that samples the tick, so it is visible 1 cycle after the tick pulse.
- count_x reflects a write or pop 1 cycle after the strobe.
- dma_req_x rises 1 cycle after count_x first satisfies the threshold. It can fall in the cycle after dma_ack_x at the earliest.
- An ack while not in REQ is ignored.
- An ack and a write in the same cycle: the write counts toward the burst.
- underrun_x and overflow_x are registered pulses, 1 cycle after the event.
- After reset or a FIFO reset, count = 0, so with sound_en = 1 the request rises 2 cycles after the reset strobe.

## Structure
- Package direct_sound_pkg holds:
  - the constants SAMPLE_W = 8, WORD_W = 32, FIFO_DEPTH = 8;
  - typedef dma_state_t {IDLE, REQ, WAIT}.
- Sub-module sound_fifo_chan is instantiated twice. It contains one channel's FIFO, byte selector and DMA FSM.
- The top level does the timer-select muxing and sound_en gating.

## Test plan
- Reset, then sound_en = 1 with no writes: dma_req_a and dma_req_b rise; ack each -> req falls and pending = 1.
- Write channel A with 0x44332211 then 0x88776655; 8 ticks of timer0 (timer_sel_a = 0):
  - sample_a sequence is 0x11, 0x22, … , 0x88;
  - count_a goes 2 -> 1 -> 0;
  - a 9th tick -> underrun_a pulses and sample_a stays 0x88.
- Write 9 words to channel B with no ticks: count_b = 8 and overflow_b pulses once on the 9th write. Then write and word-pop in the same cycle with count = 8 -> the write is accepted and count stays 8.
- timer_sel_a = 1 and timer_sel_b = 0, with timer0_ovf pulsed only: only channel B advances; sample_a is unchanged.
- Load 6 words into A, ack the request, write 4 words: the FSM returns to IDLE after the 4th write, and the request re-rises once count drops to 4.
- With A at count = 5 and byte_idx = 2, assert fifo_a_reset together with a write and a tick:
  - next cycle count_a = 0, sample_a = 0, byte_idx = 0, and there is no overflow or underrun pulse;
  - channel B is unaffected.
